// File: rtl/uart_byte_display_mux_if.sv
// Receive/display bundle between the UART receiver, the digit scanner and the
// 7-segment decoder. The master side supplies bytes and reads the display outputs.
interface uart_byte_display_mux_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       overrun;
   logic [7:0] value_out;
   logic [3:0] digit_out;
   logic [2:0] digit_sel;

   modport master (
      output rx_data, rx_valid,
      input  busy, overrun, value_out, digit_out, digit_sel
   );

   modport slave (
      input  rx_data, rx_valid,
      output busy, overrun, value_out, digit_out, digit_sel
   );
endinterface

// File: rtl/uart_byte_display_mux.sv
// Byte-to-BCD display front end: double-dabble conversion, one-deep byte buffer
// and a 3-digit scan. Define DISPLAY_LZB_EN for leading-zero blanking.
module uart_byte_display_mux #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input logic                    clk,
   input logic                    rst,
   uart_byte_display_mux_if.slave bus
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_LOAD    = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  src_q, src_d;
   logic [11:0] bcd_q, bcd_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  pend_q, pend_d;
   logic        pend_vld_q, pend_vld_d;
   logic        overrun_q, overrun_d;
   logic [11:0] disp_q, disp_d;
   logic [7:0]  value_q, value_d;

   logic        start;
   logic [7:0]  start_byte;
   logic [11:0] bcd_adj;

   logic [CNT_W-1:0] refresh_q, refresh_d;
   logic [1:0]       scan_idx_q, scan_idx_d;

   // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift.
   function automatic logic [11:0] add3(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int i = 0; i < 3; i++) begin
         if (b[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      src_d      = src_q;
      bcd_d      = bcd_q;
      bit_cnt_d  = bit_cnt_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      overrun_d  = 1'b0;
      disp_d     = disp_q;
      value_d    = value_q;
      start      = 1'b0;
      start_byte = 8'd0;
      bcd_adj    = add3(bcd_q);

      unique case (state_q)
         ST_IDLE: begin
            if (bus.rx_valid) begin
               start      = 1'b1;
               start_byte = bus.rx_data;
            end
         end

         ST_CONVERT: begin
            // Hundreds never exceeds 2 for an 8-bit input, so bit 11 can be dropped.
            {bcd_d, shift_d} = {bcd_adj[10:0], shift_q, 1'b0};
            bit_cnt_d        = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               state_d = ST_LOAD;
            end
            if (bus.rx_valid) begin
               pend_d     = bus.rx_data;
               pend_vld_d = 1'b1;
               overrun_d  = pend_vld_q;
            end
         end

         ST_LOAD: begin
            disp_d  = bcd_q;
            value_d = src_q;
            if (bus.rx_valid) begin
               start      = 1'b1;
               start_byte = bus.rx_data;
               pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
               start      = 1'b1;
               start_byte = pend_q;
               pend_vld_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start) begin
         shift_d   = start_byte;
         src_d     = start_byte;
         bcd_d     = 12'd0;
         bit_cnt_d = 3'd0;
         state_d   = ST_CONVERT;
      end
   end

   // NOTE: sequential state uses <= so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pend_vld_q <= 1'b0;
         overrun_q  <= 1'b0;
         disp_q     <= 12'd0;
         value_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         pend_vld_q <= pend_vld_d;
         overrun_q  <= overrun_d;
         disp_q     <= disp_d;
         value_q    <= value_d;
      end
   end

   // NOTE: pure datapath registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      shift_q   <= shift_d;
      src_q     <= src_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      pend_q    <= pend_d;
   end

   // Free-running scan, independent of the conversion FSM.
   always_comb begin
      refresh_d  = refresh_q + CNT_W'(1);
      scan_idx_d = scan_idx_q;
      if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
         refresh_d  = '0;
         scan_idx_d = (scan_idx_q == 2'd2) ? 2'd0 : scan_idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_q  <= '0;
         scan_idx_q <= 2'd0;
      end else begin
         refresh_q  <= refresh_d;
         scan_idx_q <= scan_idx_d;
      end
   end

   always_comb begin
      bus.digit_out = 4'd0;
      bus.digit_sel = 3'b111;
      unique case (scan_idx_q)
         2'd0: begin
            bus.digit_out = disp_q[3:0];
            bus.digit_sel = 3'b110;
         end
         2'd1: begin
            bus.digit_out = disp_q[7:4];
`ifdef DISPLAY_LZB_EN
            bus.digit_sel = (disp_q[11:4] == 8'd0) ? 3'b111 : 3'b101;
`else
            bus.digit_sel = 3'b101;
`endif
         end
         2'd2: begin
            bus.digit_out = disp_q[11:8];
`ifdef DISPLAY_LZB_EN
            bus.digit_sel = (disp_q[11:8] == 4'd0) ? 3'b111 : 3'b011;
`else
            bus.digit_sel = 3'b011;
`endif
         end
         default: begin
            bus.digit_out = 4'd0;
            bus.digit_sel = 3'b111;
         end
      endcase
   end

   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.overrun   = overrun_q;
   assign bus.value_out = value_q;

endmodule

// File: tb/tb_uart_byte_display_mux.sv
// Scoreboard bench: a transaction-level model predicts every cycle's outputs,
// a monitor on the falling edge pops and compares them.
module tb_uart_byte_display_mux;

   localparam int RD = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_byte_display_mux_if bus_if ();

   uart_byte_display_mux #(.REFRESH_DIV(RD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      int         edge_no;
      logic       busy;
      logic       ovr;
      logic [7:0] val;
      logic [3:0] dig;
      logic [2:0] sel;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // Model state: conversions as (source byte, cycle of display update).
   int         edge_no     = 0;
   bit         m_active    = 1'b0;
   int         m_load_edge = 0;
   logic [7:0] m_src       = 8'd0;
   bit         m_pend      = 1'b0;
   logic [7:0] m_pend_byte = 8'd0;
   logic [7:0] m_disp      = 8'd0;
   int         m_rst_edge  = 0;
   bit         m_ovr       = 1'b0;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
      end
   endtask

   task automatic model_start(input logic [7:0] b);
      m_active    = 1'b1;
      m_src       = b;
      m_load_edge = edge_no + 9;
   endtask

   task automatic model_tick(input bit v, input logic [7:0] d, input bit r);
      m_ovr = 1'b0;
      if (r) begin
         m_active   = 1'b0;
         m_pend     = 1'b0;
         m_disp     = 8'd0;
         m_rst_edge = edge_no;
      end else if (m_active && edge_no == m_load_edge) begin
         m_disp = m_src;
         if (v) begin
            model_start(d);
            m_pend = 1'b0;
         end else if (m_pend) begin
            model_start(m_pend_byte);
            m_pend = 1'b0;
         end else begin
            m_active = 1'b0;
         end
      end else if (!m_active) begin
         if (v) model_start(d);
      end else if (v) begin
         m_ovr       = m_pend;
         m_pend      = 1'b1;
         m_pend_byte = d;
      end
   endtask

   function automatic exp_t predict();
      exp_t e;
      int   idx;
      idx       = ((edge_no - m_rst_edge) / RD) % 3;
      e.edge_no = edge_no;
      e.busy    = m_active;
      e.ovr     = m_ovr;
      e.val     = m_disp;
      case (idx)
         0: begin
            e.dig = 4'(m_disp % 10);
            e.sel = 3'b110;
         end
         1: begin
            e.dig = 4'((m_disp / 10) % 10);
            e.sel = 3'b101;
`ifdef DISPLAY_LZB_EN
            if (m_disp < 10) e.sel = 3'b111;
`endif
         end
         default: begin
            e.dig = 4'(m_disp / 100);
            e.sel = 3'b011;
`ifdef DISPLAY_LZB_EN
            if (m_disp < 100) e.sel = 3'b111;
`endif
         end
      endcase
      return e;
   endfunction

   task automatic step(input bit v, input logic [7:0] d, input bit r);
      bus_if.rx_valid = v;
      bus_if.rx_data  = d;
      rst             = r;
      @(posedge clk);
      edge_no++;
      model_tick(v, d, r);
      exp_q.push_back(predict());
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0);
   endtask

   // Monitor: one expectation per clock edge, compared on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy",      {11'd0, bus_if.busy},    {11'd0, e.busy});
            check("overrun",   {11'd0, bus_if.overrun}, {11'd0, e.ovr});
            check("value_out", {4'd0, bus_if.value_out}, {4'd0, e.val});
            check("digit_out", {8'd0, bus_if.digit_out}, {8'd0, e.dig});
            check("digit_sel", {9'd0, bus_if.digit_sel}, {9'd0, e.sel});
         end
      end
   end

   initial begin
      bus_if.rx_valid = 1'b0;
      bus_if.rx_data  = 8'd0;
      rst             = 1'b1;

      step(1'b0, 8'd0, 1'b1);
      step(1'b0, 8'd0, 1'b1);
      idle(5);

      // Single byte, maximum value.
      step(1'b1, 8'd255, 1'b0);
      idle(30);

      // Leading-zero case.
      step(1'b1, 8'd7, 1'b0);
      idle(30);

      // Burst: 34 gets buffered then overwritten by 56.
      step(1'b1, 8'd12, 1'b0);
      step(1'b1, 8'd34, 1'b0);
      step(1'b1, 8'd56, 1'b0);
      idle(30);

      // Second strobe lands exactly on the display-update cycle.
      step(1'b1, 8'd100, 1'b0);
      idle(8);
      step(1'b1, 8'd43, 1'b0);
      idle(30);

      // Reset in the middle of a conversion.
      step(1'b1, 8'd200, 1'b0);
      idle(3);
      step(1'b0, 8'd0, 1'b1);
      idle(30);

      // Random traffic with occasional resets.
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 199) == 0));
      end
      idle(30);

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
